osc_ce_gen: RTL and testbench



---
 rtl/osc_ce_gen.sv | 157 +++++++++++++++
 tb/tb_osc_ce_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/osc_ce_gen.sv
// osc_ce_gen: power-on reset hold plus two fractional clock-enable strobes.
// The design runs on the oscillator clock. A reset hold of POR_CYCLES clocks
// comes first. After it, numerator/denominator accumulators produce the CPU
// and pixel enables at exact long-term rates.
// Optional feature macro: OSC_CE_COUNT_EN adds a 16-bit count of cpu_ce
// strobes (cpu_ce_count).
module osc_ce_gen #(
  parameter int CPU_NUM    = 14,
  parameter int CPU_DEN    = 125,
  parameter int PIX_NUM    = 28,
  parameter int PIX_DEN    = 125,
  parameter int POR_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
`ifdef OSC_CE_COUNT_EN
  output logic [15:0] cpu_ce_count,
`endif
  output logic        rst_out,
  output logic        ready,
  output logic        cpu_ce,
  output logic        pix_ce
);

  localparam int MAX_DEN = (CPU_DEN > PIX_DEN) ? CPU_DEN : PIX_DEN;
  localparam int ACC_W   = $clog2(MAX_DEN) + 1;

  localparam logic [ACC_W-1:0] CPU_NUM_W = ACC_W'(CPU_NUM);
  localparam logic [ACC_W-1:0] CPU_DEN_W = ACC_W'(CPU_DEN);
  localparam logic [ACC_W-1:0] PIX_NUM_W = ACC_W'(PIX_NUM);
  localparam logic [ACC_W-1:0] PIX_DEN_W = ACC_W'(PIX_DEN);
  localparam logic [15:0]      HOLD_LAST = 16'(POR_CYCLES - 1);

  // Illegal rate pairs or hold lengths stop elaboration.
  if (!(CPU_NUM > 0 && CPU_NUM <= CPU_DEN)) begin : g_bad_cpu_ratio
    $error("osc_ce_gen: CPU_NUM must satisfy 0 < CPU_NUM <= CPU_DEN");
  end
  if (!(PIX_NUM > 0 && PIX_NUM <= PIX_DEN)) begin : g_bad_pix_ratio
    $error("osc_ce_gen: PIX_NUM must satisfy 0 < PIX_NUM <= PIX_DEN");
  end
  if (!(POR_CYCLES >= 1 && POR_CYCLES <= 65535)) begin : g_bad_por
    $error("osc_ce_gen: POR_CYCLES must be in 1..65535");
  end

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [15:0]      r_hold_cnt;
  logic [15:0]      w_hold_cnt_nxt;
  logic [ACC_W-1:0] r_cpu_acc;
  logic [ACC_W-1:0] r_pix_acc;
  logic [ACC_W-1:0] w_cpu_acc_nxt;
  logic [ACC_W-1:0] w_pix_acc_nxt;
  logic [ACC_W-1:0] w_cpu_sum;
  logic [ACC_W-1:0] w_pix_sum;
  logic             r_cpu_ce;
  logic             r_pix_ce;
  logic             w_cpu_ce_nxt;
  logic             w_pix_ce_nxt;
  logic             r_rst_out;
  logic             r_ready;
  logic             w_rst_out_nxt;
  logic             w_ready_nxt;

  // State register: HOLD after reset, RUN once the hold count expires.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HOLD;
    else     r_state <= w_next_state;
  end

  // Next-state logic: RUN is absorbing; only rst leads back to HOLD.
  always_comb begin
    // NOTE: default assignment first, so no path through this block infers a latch.
    w_next_state = r_state;
    if (r_state == S_HOLD && r_hold_cnt == HOLD_LAST) w_next_state = S_RUN;
  end

  // Sums never overflow ACC_W, because acc < DEN and NUM <= DEN.
  assign w_cpu_sum = r_cpu_acc + CPU_NUM_W;
  assign w_pix_sum = r_pix_acc + PIX_NUM_W;

  // Output/datapath logic: next values of the hold counter, the accumulators,
  // and every registered output.
  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    w_cpu_acc_nxt  = r_cpu_acc;
    w_pix_acc_nxt  = r_pix_acc;
    w_cpu_ce_nxt   = 1'b0;
    w_pix_ce_nxt   = 1'b0;
    w_rst_out_nxt  = (w_next_state == S_HOLD);
    w_ready_nxt    = (w_next_state == S_RUN);
    if (r_state == S_HOLD) begin
      // pause has no effect here; the accumulators wait at zero.
      if (r_hold_cnt != HOLD_LAST) w_hold_cnt_nxt = r_hold_cnt + 16'd1;
    end else if (!pause) begin
      if (w_cpu_sum >= CPU_DEN_W) begin
        w_cpu_acc_nxt = w_cpu_sum - CPU_DEN_W;
        w_cpu_ce_nxt  = 1'b1;
      end else begin
        w_cpu_acc_nxt = w_cpu_sum;
      end
      if (w_pix_sum >= PIX_DEN_W) begin
        w_pix_acc_nxt = w_pix_sum - PIX_DEN_W;
        w_pix_ce_nxt  = 1'b1;
      end else begin
        w_pix_acc_nxt = w_pix_sum;
      end
    end
  end

  // Datapath and output registers. Every output comes straight from a flop,
  // so pause has no combinational path to any output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= 16'd0;
      r_cpu_acc  <= '0;
      r_pix_acc  <= '0;
      r_cpu_ce   <= 1'b0;
      r_pix_ce   <= 1'b0;
      r_rst_out  <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      r_cpu_acc  <= w_cpu_acc_nxt;
      r_pix_acc  <= w_pix_acc_nxt;
      r_cpu_ce   <= w_cpu_ce_nxt;
      r_pix_ce   <= w_pix_ce_nxt;
      r_rst_out  <= w_rst_out_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign rst_out = r_rst_out;
  assign ready   = r_ready;
  assign cpu_ce  = r_cpu_ce;
  assign pix_ce  = r_pix_ce;

`ifdef OSC_CE_COUNT_EN
  logic [15:0] r_cpu_ce_count;

  // Strobe counter: it advances on the same edge that raises cpu_ce.
  // pause forces that strobe low, so the count freezes while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_cpu_ce_count <= 16'd0;
    else if (w_cpu_ce_nxt) r_cpu_ce_count <= r_cpu_ce_count + 16'd1;
  end

  assign cpu_ce_count = r_cpu_ce_count;
`endif

endmodule

// File: tb/tb_osc_ce_gen.sv
// tb_osc_ce_gen: scoreboard bench for osc_ce_gen with default parameters.
// For each clock, the driver pushes the expected outputs into a queue. A
// monitor on the falling edge pops each entry and compares it. Directed
// checks cover the hold length, first-strobe positions, rates, pause and
// mid-run reset.
module tb_osc_ce_gen;

  localparam int POR     = 16;
  localparam int CPU_NUM = 14;
  localparam int CPU_DEN = 125;
  localparam int PIX_NUM = 28;
  localparam int PIX_DEN = 125;

  typedef struct packed {
    logic        rst_out;
    logic        ready;
    logic        cpu_ce;
    logic        pix_ce;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic rst_out, ready, cpu_ce, pix_ce;
`ifdef OSC_CE_COUNT_EN
  logic [15:0] cpu_ce_count;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state
  bit   m_run, m_rst_out, m_ready, m_cpu_ce, m_pix_ce;
  int   m_hold, m_cpu_acc, m_pix_acc, m_cnt;

  osc_ce_gen dut (
    .clk          (clk),
    .rst          (rst),
    .pause        (pause),
`ifdef OSC_CE_COUNT_EN
    .cpu_ce_count (cpu_ce_count),
`endif
    .rst_out      (rst_out),
    .ready        (ready),
    .cpu_ce       (cpu_ce),
    .pix_ce       (pix_ce)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_hold = 0; m_cpu_acc = 0; m_pix_acc = 0;
    m_cpu_ce = 0; m_pix_ce = 0; m_rst_out = 1; m_ready = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit p);
    if (!m_run) begin
      m_cpu_ce = 0; m_pix_ce = 0;
      if (m_hold == POR - 1) begin
        m_run = 1; m_rst_out = 0; m_ready = 1;
      end else begin
        m_hold++;
      end
    end else if (p) begin
      m_cpu_ce = 0; m_pix_ce = 0;
    end else begin
      m_cpu_acc += CPU_NUM;
      m_cpu_ce = (m_cpu_acc >= CPU_DEN);
      if (m_cpu_ce) m_cpu_acc -= CPU_DEN;
      m_pix_acc += PIX_NUM;
      m_pix_ce = (m_pix_acc >= PIX_DEN);
      if (m_pix_ce) m_pix_acc -= PIX_DEN;
    end
    if (m_cpu_ce) m_cnt = (m_cnt + 1) & 32'hFFFF;
  endtask

  // One clock: drive pause, queue the expected outputs, and return just
  // after the monitor has checked the falling-edge sample.
  task automatic step(input bit p);
    exp_t e;
    pause = p;
    model_step(p);
    e.rst_out = m_rst_out; e.ready = m_ready;
    e.cpu_ce = m_cpu_ce; e.pix_ce = m_pix_ce; e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per clock and compares it with the DUT.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rst_out", 32'(rst_out), 32'(e.rst_out));
      check("ready",   32'(ready),   32'(e.ready));
      check("cpu_ce",  32'(cpu_ce),  32'(e.cpu_ce));
      check("pix_ce",  32'(pix_ce),  32'(e.pix_ce));
`ifdef OSC_CE_COUNT_EN
      check("cpu_ce_count", 32'(cpu_ce_count), 32'(e.cnt));
`endif
    end
  end

  // Watchdog: a hung run stops with a FAIL line.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, first_cpu, first_pix, cpu_cnt, pix_cnt, wide;
    int  p_cpu, p_pix;
    bit  prev_cpu, prev_pix, found;
    bit  ref_cpu[125], ref_pix[125];
`ifdef OSC_CE_COUNT_EN
    logic [15:0] cnt_before;
`endif

    // Reset for 3 clocks, then check the reset state.
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset rst_out", 32'(rst_out), 32'd1);
    check("reset ready",   32'(ready),   32'd0);
    check("reset cpu_ce",  32'(cpu_ce),  32'd0);
    check("reset pix_ce",  32'(pix_ce),  32'd0);
    rst = 1'b0;

    // Hold: rst_out must fall exactly 16 edges after release.
    n = 0;
    while (rst_out && n < 40) begin step(0); n++; end
    check("hold edges", 32'(n), 32'd16);
    check("ready at run entry", 32'(ready), 32'd1);

    // First strobes and exact rate over 12500 unpaused clocks
    first_cpu = 0; first_pix = 0; cpu_cnt = 0; pix_cnt = 0; wide = 0;
    prev_cpu = 0; prev_pix = 0;
    for (int e = 1; e <= 12500; e++) begin
      step(0);
      if (cpu_ce && first_cpu == 0) first_cpu = e;
      if (pix_ce && first_pix == 0) first_pix = e;
      if (cpu_ce) cpu_cnt++;
      if (pix_ce) pix_cnt++;
      if ((cpu_ce && prev_cpu) || (pix_ce && prev_pix)) wide++;
      prev_cpu = cpu_ce; prev_pix = pix_ce;
      if (e >= 21 && e <= 145) begin
        ref_cpu[e-21] = cpu_ce; ref_pix[e-21] = pix_ce;
      end
    end
    check("first pix_ce clk", 32'(first_pix), 32'd5);
    check("first cpu_ce clk", 32'(first_cpu), 32'd9);
    check("cpu_ce count 12500", 32'(cpu_cnt), 32'd1400);
    check("pix_ce count 12500", 32'(pix_cnt), 32'd2800);
    check("wide pulses", 32'(wide), 32'd0);
    check("cpu_acc at end", 32'(dut.r_cpu_acc), 32'd0);
    check("pix_acc at end", 32'(dut.r_pix_acc), 32'd0);

    // Pause for 37 clocks mid-run. The sequence afterwards must match the
    // unpaused reference from the same phase.
    repeat (20) step(0);
`ifdef OSC_CE_COUNT_EN
    cnt_before = cpu_ce_count;
`endif
    n = 0;
    repeat (37) begin step(1); if (cpu_ce || pix_ce) n++; end
    check("strobes during pause", 32'(n), 32'd0);
`ifdef OSC_CE_COUNT_EN
    check("count frozen in pause", 32'(cpu_ce_count), 32'(cnt_before));
`endif
    cpu_cnt = 0; pix_cnt = 0; p_cpu = 0; p_pix = 0;
    for (int j = 0; j < 125; j++) begin
      step(0);
      if (cpu_ce) cpu_cnt++;
      if (pix_ce) pix_cnt++;
      if (cpu_ce !== ref_cpu[j]) p_cpu++;
      if (pix_ce !== ref_pix[j]) p_pix++;
    end
    check("cpu_ce count after pause", 32'(cpu_cnt), 32'd14);
    check("pix_ce count after pause", 32'(pix_cnt), 32'd28);
    check("cpu seq shift mismatches", 32'(p_cpu), 32'd0);
    check("pix seq shift mismatches", 32'(p_pix), 32'd0);

    // Irregular pause pattern, checked by the scoreboard
    for (int i = 0; i < 300; i++) step((i % 7) == 3 || (i % 11) == 5);

    // Reset mid-run, applied during a cpu_ce cycle
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(0);
      found = m_cpu_ce;
    end
    check("found cpu_ce cycle", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("async cpu_ce drop", 32'(cpu_ce),  32'd0);
    check("async rst_out",     32'(rst_out), 32'd1);
    check("async ready",       32'(ready),   32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    n = 0;
    while (rst_out && n < 40) begin step(0); n++; end
    check("hold replay edges", 32'(n), 32'd16);
    repeat (20) step(0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
